// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word/register widths, ALU opcodes and the
// ID/EX pipeline register layout used by the operand stage.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'h0,
        ALU_SRL  = 4'h1,
        ALU_ADD  = 4'h2,
        ALU_SUB  = 4'h3,
        ALU_AND  = 4'h4,
        ALU_OR   = 4'h5,
        ALU_XOR  = 4'h6,
        ALU_NOR  = 4'h7,
        ALU_SLT  = 4'h8,
        ALU_SLTU = 4'h9
    } aluop_t;

    // Operand source chosen by the forwarding logic
    typedef enum logic [1:0] {
        FWD_NONE  = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_t;

    // Fields latched by the ID/EX pipeline register
    typedef struct packed {
        logic     valid;
        regbits_t rs;
        regbits_t rt;
        word_t    rdata1;
        word_t    rdata2;
        word_t    imm;
        logic     alusrc;
        aluop_t   aluop;
        regbits_t dest;
        logic     regwrite;
    } idex_t;

endpackage

// File: rtl/ex_operand_if.sv
// Bundle of the operand-stage signals, in the same modport style as the ALU
// interface: stage drives the EX-side outputs, tb drives the stimulus.
interface ex_operand_if
    import cpu_types_pkg::*;
(
    input logic CLK
);
    logic     RST;
    logic     id_valid;
    regbits_t id_rs;
    regbits_t id_rt;
    word_t    id_rdata1;
    word_t    id_rdata2;
    word_t    id_imm;
    logic     id_alusrc;
    aluop_t   id_aluop;
    regbits_t id_dest;
    logic     id_regwrite;
    logic     stall;
    logic     flush;
    logic     exmem_regwrite;
    regbits_t exmem_dest;
    word_t    exmem_result;
    logic     memwb_regwrite;
    regbits_t memwb_dest;
    word_t    memwb_wdata;
    logic     ex_valid;
    word_t    portA;
    word_t    portB;
    aluop_t   aluop;
    word_t    ex_storedata;
    regbits_t ex_dest;
    logic     ex_regwrite;

    modport stage (
        input  CLK, RST, id_valid, id_rs, id_rt, id_rdata1, id_rdata2, id_imm,
               id_alusrc, id_aluop, id_dest, id_regwrite, stall, flush,
               exmem_regwrite, exmem_dest, exmem_result,
               memwb_regwrite, memwb_dest, memwb_wdata,
        output ex_valid, portA, portB, aluop, ex_storedata, ex_dest, ex_regwrite
    );

    modport tb (
        input  CLK, ex_valid, portA, portB, aluop, ex_storedata, ex_dest, ex_regwrite,
        output RST, id_valid, id_rs, id_rt, id_rdata1, id_rdata2, id_imm,
               id_alusrc, id_aluop, id_dest, id_regwrite, stall, flush,
               exmem_regwrite, exmem_dest, exmem_result,
               memwb_regwrite, memwb_dest, memwb_wdata
    );

endinterface

// File: rtl/ex_operand_stage_fwd_mux.sv
// Priority forwarding select for one source operand: EX/MEM beats MEM/WB,
// register 0 is never forwarded.
module fwd_mux
    import cpu_types_pkg::*;
(
    input  regbits_t rs,
    input  word_t    rdata,
    input  logic     exmem_regwrite,
    input  regbits_t exmem_dest,
    input  word_t    exmem_result,
    input  logic     memwb_regwrite,
    input  regbits_t memwb_dest,
    input  word_t    memwb_wdata,
    output word_t    value
);

    fwd_sel_t sel;

    // Resolve the hazard source, then pick the matching data word
    always_comb begin
        sel = FWD_NONE;
        if (exmem_regwrite && (exmem_dest != '0) && (exmem_dest == rs))
            sel = FWD_EXMEM;
        else if (memwb_regwrite && (memwb_dest != '0) && (memwb_dest == rs))
            sel = FWD_MEMWB;

        case (sel)
            FWD_EXMEM: value = exmem_result;
            FWD_MEMWB: value = memwb_wdata;
            default:   value = rdata;
        endcase
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding, feeding the ALU ports,
// the store-data path and the writeback controls for EX/MEM.
module ex_operand_stage
    import cpu_types_pkg::*;
(
    input  logic     CLK,
    input  logic     RST,
    input  logic     id_valid,
    input  regbits_t id_rs,
    input  regbits_t id_rt,
    input  word_t    id_rdata1,
    input  word_t    id_rdata2,
    input  word_t    id_imm,
    input  logic     id_alusrc,
    input  aluop_t   id_aluop,
    input  regbits_t id_dest,
    input  logic     id_regwrite,
    input  logic     stall,
    input  logic     flush,
    input  logic     exmem_regwrite,
    input  regbits_t exmem_dest,
    input  word_t    exmem_result,
    input  logic     memwb_regwrite,
    input  regbits_t memwb_dest,
    input  word_t    memwb_wdata,
    output logic     ex_valid,
    output word_t    portA,
    output word_t    portB,
    output aluop_t   aluop,
    output word_t    ex_storedata,
    output regbits_t ex_dest,
    output logic     ex_regwrite
);

    idex_t r;
    word_t fwd_a;
    word_t fwd_b;

    fwd_mux u_fwd_a (
        .rs             (r.rs),
        .rdata          (r.rdata1),
        .exmem_regwrite (exmem_regwrite),
        .exmem_dest     (exmem_dest),
        .exmem_result   (exmem_result),
        .memwb_regwrite (memwb_regwrite),
        .memwb_dest     (memwb_dest),
        .memwb_wdata    (memwb_wdata),
        .value          (fwd_a)
    );

    fwd_mux u_fwd_b (
        .rs             (r.rt),
        .rdata          (r.rdata2),
        .exmem_regwrite (exmem_regwrite),
        .exmem_dest     (exmem_dest),
        .exmem_result   (exmem_result),
        .memwb_regwrite (memwb_regwrite),
        .memwb_dest     (memwb_dest),
        .memwb_wdata    (memwb_wdata),
        .value          (fwd_b)
    );

    // Pipeline register: reset > flush (bubble) > stall (hold, refresh operands) > load
    always_ff @(posedge CLK) begin
        if (RST) begin
            r <= '0;
        end else if (flush) begin
            r <= '0;
        end else if (stall) begin
            // Capture forwarded values so data retiring during the stall is kept
            r.rdata1 <= fwd_a;
            r.rdata2 <= fwd_b;
        end else begin
            r.valid    <= id_valid;
            r.rs       <= id_rs;
            r.rt       <= id_rt;
            r.rdata1   <= id_rdata1;
            r.rdata2   <= id_rdata2;
            r.imm      <= id_imm;
            r.alusrc   <= id_alusrc;
            r.aluop    <= id_aluop;
            r.dest     <= id_dest;
            r.regwrite <= id_regwrite;
        end
    end

    // Output muxing toward the ALU and EX/MEM latch
    always_comb begin
        ex_valid     = r.valid;
        portA        = fwd_a;
        portB        = r.alusrc ? r.imm : fwd_b;
        aluop        = r.aluop;
        ex_storedata = fwd_b;
        ex_dest      = r.dest;
        ex_regwrite  = r.regwrite & r.valid;
    end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register plus operand-forwarding muxes, directly upstream of the ALU.
- Latches decoded operands and controls, resolves RAW hazards from the EX/MEM and MEM/WB stages, and drives the ALU's portA, portB and aluop inputs.
- Also supplies the forwarded store-data word and the destination/writeback controls to the EX/MEM latch.

Parameters:
- None. All widths come from cpu_types_pkg: word_t is 32 bits, regbits_t is 5 bits, aluop_t is 4 bits.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- id_valid  in  1  decode stage holds a real instruction
- id_rs  in  5  source register A index
- id_rt  in  5  source register B index
- id_rdata1  in  32  register-file read of rs
- id_rdata2  in  32  register-file read of rt
- id_imm  in  32  immediate, already extended by decode
- id_alusrc  in  1  1 = portB takes the immediate
- id_aluop  in  4  aluop_t for this instruction
- id_dest  in  5  writeback register index
- id_regwrite  in  1  instruction writes the register file
- stall  in  1  hold the stage contents
- flush  in  1  squash; insert a bubble
- exmem_regwrite  in  1  EX/MEM stage writes a register
- exmem_dest  in  5  EX/MEM destination index
- exmem_result  in  32  EX/MEM ALU result
- memwb_regwrite  in  1  MEM/WB stage writes a register
- memwb_dest  in  5  MEM/WB destination index
- memwb_wdata  in  32  MEM/WB writeback data
- ex_valid  out  1  stage holds a real instruction
- portA  out  32  ALU operand A
- portB  out  32  ALU operand B
- aluop  out  4  ALU operation
- ex_storedata  out  32  forwarded rt value, for stores
- ex_dest  out  5  latched destination index
- ex_regwrite  out  1  latched regwrite, gated by ex_valid

Behaviour:
- Register update on the rising CLK edge, priority order:
  - RST: clear everything.
  - flush: load a bubble.
  - stall: hold, with refresh (see below).
  - otherwise: load the id_* inputs.
- Reset and bubble values: all latched fields 0. So ex_valid=0, ex_regwrite=0, aluop=4'h0, ex_dest=0, latched rdata/imm=0.
- flush during stall: flush wins.
- Latency: an instruction presented at ID in cycle N appears at the outputs in cycle N+1.
- Forwarding is combinational on the latched rs/rt, per operand X in {A, B-reg}:
  - if exmem_regwrite and exmem_dest!=0 and exmem_dest==rsX, select exmem_result;
  - else if memwb_regwrite and memwb_dest!=0 and memwb_dest==rsX, select memwb_wdata;
  - else select the latched rdata.
  - EX/MEM always beats MEM/WB. Index 0 is never forwarded.
- Output muxes:
  - portA = forwarded A.
  - portB = alusrc ? latched imm : forwarded B.
  - ex_storedata = forwarded B regardless of alusrc.
- Stall refresh: while stall=1 and flush=0, latched rdata1/rdata2 are overwritten each cycle with the current forwarded A/B values. All other fields hold. A MEM/WB value that retires during a stall is therefore not lost.
- ex_regwrite = latched regwrite AND ex_valid. When ex_valid=0, the other outputs are don't-care but must match the rules above (no X).
- No internal state other than the pipeline register.

Decomposition:
- word_t, regbits_t and aluop_t come from the existing cpu_types_pkg.
- Add to cpu_types_pkg:
  - typedef fwd_sel_t, enum {FWD_NONE, FWD_EXMEM, FWD_MEMWB};
  - struct idex_t bundling the latched fields.
- Natural sub-module: fwd_mux, a combinational priority select used twice (operands A and B).
- Companion interface ex_operand_if follows the same modport style as the existing ALU interface: modport stage, modport tb.

Test Plan:
- No hazard: id_rs=3, rdata1=0x10, id_rt=4, rdata2=0x20, alusrc=0, aluop=ADD. Next cycle: portA=0x10, portB=0x20, ex_valid=1.
- Dual-hit priority: latched rs=5 with exmem (regwrite=1, dest=5, result=0xAAAA) and memwb (regwrite=1, dest=5, wdata=0xBBBB). Expect portA=0xAAAA. Drop exmem_regwrite: portA=0xBBBB.
- Register zero: latched rt=0, exmem_dest=0, exmem_regwrite=1, result=0xFFFF, rdata2=0. Expect portB=0 and ex_storedata=0.
- Stall refresh: latched rs=7 with rdata1=0x1. Assert stall for 2 cycles; in cycle 1 memwb forwards dest=7, wdata=0x77; in cycle 2 nothing forwards. Expect portA=0x77 in both cycles. After release, the new ID instruction loads.
- Flush and stall together: stall=1, flush=1, id_valid=1, id_regwrite=1. Next cycle: ex_valid=0, ex_regwrite=0, aluop=0.
- Reset mid-stream: RST pulsed while ex_valid=1 with alusrc=1 and imm=0x8. Next cycle: all outputs 0, portB=0.
